// File: rtl/gp_fb_pkg.sv
// gp_fb_pkg: shared framebuffer geometry, pixel/coordinate types and clear FSM states.
package gp_fb_pkg;
    localparam int FB_WIDTH = 640;
    localparam int FB_HEIGHT = 480;
    typedef logic [3:0] pixel_t;
    typedef logic [9:0] coord_t;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} fb_state_t;
endpackage

// File: rtl/fb_write_port_if.sv
// fb_write_port_if: rasterizer write, clear control and scanout read signals of the framebuffer port.
interface fb_write_port_if;
    import gp_fb_pkg::*;
    coord_t fb_x;
    coord_t fb_y;
    pixel_t data;
    logic fb_we;
    logic clear_start;
    pixel_t clear_color;
    logic rd_en;
    coord_t rd_x;
    coord_t rd_y;
    pixel_t rd_data;
    logic rd_valid;
    logic clear_busy;
    logic clear_done;
    logic [15:0] drop_count;
    modport master (
        output fb_x, fb_y, data, fb_we, clear_start, clear_color, rd_en, rd_x, rd_y,
        input rd_data, rd_valid, clear_busy, clear_done, drop_count
    );
    modport slave (
        input fb_x, fb_y, data, fb_we, clear_start, clear_color, rd_en, rd_x, rd_y,
        output rd_data, rd_valid, clear_busy, clear_done, drop_count
    );
endinterface

// File: rtl/fb_write_port_ram.sv
// fb_ram: simple dual-port pixel RAM, one write port and one registered read-first read port.
module fb_ram
    import gp_fb_pkg::*;
#(
    parameter int DEPTH = FB_WIDTH * FB_HEIGHT,
    parameter int AW = $clog2(DEPTH)
) (
    input logic clk,
    input logic we,
    input logic [AW-1:0] waddr,
    input pixel_t wdata,
    input logic re,
    input logic [AW-1:0] raddr,
    output pixel_t q
);
    pixel_t mem [DEPTH];
    // Non-blocking read alongside the write returns the old word on an address collision.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) q <= mem[raddr];
    end
endmodule

// File: rtl/fb_write_port.sv
// fb_write_port: framebuffer endpoint of the rasterizer pixel writes, with scanout read port,
// full-frame clear engine and saturating dropped-write counter.
module fb_write_port
    import gp_fb_pkg::*;
#(
    parameter int WIDTH = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT
) (
    input logic clk,
    input logic areset,
    fb_write_port_if.slave bus
);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    fb_state_t state;
    logic [AW-1:0] clr_addr, wr_addr, rd_addr, ram_waddr;
    pixel_t clr_color, ram_wdata, ram_q;
    logic wr_ok, rd_ok, ram_we, drop, rd_v1, rd_ok1;
    assign wr_ok = int'(bus.fb_x) < WIDTH && int'(bus.fb_y) < HEIGHT;
    assign rd_ok = int'(bus.rd_x) < WIDTH && int'(bus.rd_y) < HEIGHT;
    assign wr_addr = AW'(int'(bus.fb_y) * WIDTH + int'(bus.fb_x));
    // Out-of-range reads still go through the pipeline but never index past the RAM.
    assign rd_addr = rd_ok ? AW'(int'(bus.rd_y) * WIDTH + int'(bus.rd_x)) : '0;
    assign ram_we = state == CLEAR || (state == IDLE && bus.fb_we && wr_ok);
    assign ram_waddr = state == CLEAR ? clr_addr : wr_addr;
    assign ram_wdata = state == CLEAR ? clr_color : bus.data;
    assign drop = bus.fb_we && (state != IDLE || !wr_ok);
    fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk(clk),
        .we(ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re(bus.rd_en),
        .raddr(rd_addr),
        .q(ram_q)
    );
    always_ff @(posedge clk or posedge areset)
        if (areset) begin
            state <= IDLE;
            clr_addr <= '0;
            clr_color <= '0;
            bus.clear_busy <= 1'b0;
            bus.clear_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.clear_start) begin
                    state <= CLEAR;
                    clr_addr <= '0;
                    clr_color <= bus.clear_color;
                    bus.clear_busy <= 1'b1;
                end
                CLEAR: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == LAST) begin
                        state <= DONE;
                        bus.clear_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    bus.clear_busy <= 1'b0;
                    bus.clear_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    always_ff @(posedge clk or posedge areset)
        if (areset) begin
            rd_v1 <= 1'b0;
            rd_ok1 <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data <= '0;
            bus.drop_count <= '0;
        end else begin
            rd_v1 <= bus.rd_en;
            rd_ok1 <= rd_ok;
            bus.rd_valid <= rd_v1;
            bus.rd_data <= rd_v1 && rd_ok1 ? ram_q : '0;
            if (drop && bus.drop_count != 16'hFFFF) bus.drop_count <= bus.drop_count + 16'd1;
        end
endmodule

// File: doc/fb_write_port.md
# fb_write_port

Framebuffer-side endpoint of the rasterizer pixel-write interface (`fb_x`, `fb_y`, `data`, `fb_we`). It accepts 4-bit pixel writes from `rasterizer_unit`, stores them in a WIDTH×HEIGHT pixel RAM, and serves a separate registered read port for display scanout. It also provides a hardware clear engine and a saturating counter of dropped writes. It sits between the rasterizer and the video timing/scanout logic.

## Interface
- `WIDTH`, default `FB_WIDTH` (640): pixels per line.
- `HEIGHT`, default `FB_HEIGHT` (480): lines per frame.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `fb_x`  in  10  write column from the rasterizer.
- `fb_y`  in  10  write row from the rasterizer.
- `data`  in  4  write pixel value.
- `fb_we`  in  1  write strobe; one pixel per cycle while high.
- `clear_start`  in  1  single-cycle pulse that starts a full-frame clear.
- `clear_color`  in  4  fill value; sampled on the cycle `clear_start` is accepted.
- `rd_en`  in  1  scanout read request.
- `rd_x`  in  10  scanout read column.
- `rd_y`  in  10  scanout read row.
- `rd_data`  out  4  read pixel value.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `clear_busy`  out  1  high while a clear is in progress.
- `clear_done`  out  1  one-cycle pulse when a clear completes.
- `drop_count`  out  16  number of dropped writes; saturates at 16'hFFFF.

## Operation
- Address mapping: pixel address = `y*WIDTH + x`. The address is computed combinationally; the multiply is a constant multiply.
- Write path, state IDLE: when `fb_we` is high, `fb_x < WIDTH` and `fb_y < HEIGHT`, `data` is written to the RAM at that address.
- Writes are dropped, and `drop_count` incremented, in two cases:
  - the write is out of range;
  - `fb_we` is high while in CLEAR or DONE.
- Clear FSM states are IDLE, CLEAR and DONE.
  - IDLE→CLEAR on `clear_start`. Latch `clear_color` and zero the clear address counter.
  - CLEAR: write the latched colour to the address held in the counter, then increment the counter. After address `WIDTH*HEIGHT-1` is written, go to DONE.
  - DONE: `clear_done`=1 for this one cycle only, then go to IDLE.
  - `clear_start` is ignored in CLEAR and DONE.
- `clear_busy` = (state != IDLE).
- Read path: a request with `rd_en` high at cycle N returns `rd_data` and `rd_valid`=1 at N+2 (one cycle for the RAM registered read, one for the output register).
  - An out-of-range read returns `rd_data`=0 with `rd_valid`=1.
  - Reads are always serviced, including during a clear.
- Same-address write and read in the same cycle is read-first: the read returns the old value.
- `drop_count` increments by at most 1 per cycle and holds at 16'hFFFF once saturated.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `clear_busy`=0, `clear_done`=0, `drop_count`=0, state=IDLE, clear counter=0.
- RAM contents are not reset.
- A write accepted at cycle N is visible to a read issued at N+1 or later.
- Clear duration: `clear_start` accepted at cycle N gives `clear_busy` high from N+1 through N+WIDTH*HEIGHT+1, and `clear_done` high at N+WIDTH*HEIGHT+1.
- Reset mid-clear: return to IDLE immediately. Pixels already cleared keep the clear colour; the remaining pixels keep their old contents. No `clear_done` is produced.
- `fb_we` together with `clear_start` in the same IDLE cycle: the write is performed, then the clear begins next cycle and overwrites it.
- No backpressure to the rasterizer; accepted throughput is one pixel per cycle.

## Structure
- Package `gp_fb_pkg` holds:
  - `FB_WIDTH` and `FB_HEIGHT`;
  - `typedef logic [3:0] pixel_t`;
  - `typedef logic [9:0] coord_t`;
  - `typedef enum {IDLE, CLEAR, DONE} fb_state_t`.
- Sub-module `fb_ram`: simple dual-port RAM with one write port and one registered read port, read-first, depth WIDTH*HEIGHT, 4-bit width, written for block-RAM inference.
- The top level holds address computation, the write mux (rasterizer vs. clear engine), the clear FSM, the output register and the drop counter.

## Test plan
- Write (69,69,4'hA), then read (69,69) two cycles later → `rd_data`=4'hA, with `rd_valid` at request+2.
- Write (640,0,4'h5) and write (0,480,4'h5) → no RAM change (read (0,0) unchanged); `drop_count`=2; read (640,0) → `rd_data`=0 with `rd_valid`=1.
- Build with WIDTH=16, HEIGHT=8 and pulse `clear_start` with colour 4'h3:
  - `clear_busy` stays high 129 cycles, then one `clear_done` pulse;
  - reads of (0,0) and (15,7) → 3;
  - an `fb_we` during the clear → dropped, `drop_count`=1.
- Write (5,5,4'h1), then in one cycle write (5,5,4'h7) and read (5,5) → that read returns 4'h1; the next read returns 4'h7.
- With 16×8, assert `areset` 10 cycles into a clear:
  - outputs return to reset values immediately;
  - pixel (9,0) = clear colour and pixel (15,7) = old value;
  - a new `clear_start` is accepted.
- Force `drop_count` to 16'hFFFE and issue 3 out-of-range writes → `drop_count`=16'hFFFF.
